dmac_ahb_periph_slave: RTL and testbench



---
 rtl/dmac_ahb_periph_slave.sv | 153 +++++++++++++++
 tb/tb_dmac_ahb_periph_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ahb_periph_slave.sv
// AHB-Lite DMA sink: word writes fill a FIFO drained over valid/ready; dreq tracks free space. Zero-wait data phase, read data registered at address accept.
// Backpressure: full FIFO stalls the DATA write data phase (HREADYOUT=0) until a pop frees a slot; illegal accesses get a two-cycle ERROR.
module dmac_ahb_periph_slave #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        dreq,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_STALL, S_ERR1, S_ERR2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     mem [DEPTH];
  logic [4:0]      thresh;
  logic            enable;
  logic [1:0]      dp_addr;
  logic            dp_write, dp_word;

  logic            acc, take, addr_err, full, empty, pop;
  logic            dp_active, push_req, stall, dp_done, push, reg_wr, flush;
  logic [5:0]      space;
  logic [31:0]     rd_val;
  logic            unused_ok;

  assign unused_ok = ^{HBURST, HADDR[31:4]};

  assign acc      = HSEL & HTRANS[1] & HREADY;
  assign addr_err = (HADDR[1:0] != 2'b00) | (HWRITE & (HADDR[3:2] == 2'd0) & (HSIZE != 3'b010));
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  assign out_valid = enable & ~empty;
  assign out_data  = empty ? 32'd0 : mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  assign dp_active = (state == S_DATA) | (state == S_STALL);
  assign push_req  = dp_active & dp_write & (dp_addr == 2'd0);
  // A pop in the same cycle frees the slot, so a full FIFO need not stall.
  assign stall     = push_req & full & ~pop;
  assign dp_done   = dp_active & ~stall;
  assign reg_wr    = dp_done & dp_write & dp_word;
  assign flush     = reg_wr & (dp_addr == 2'd3) & HWDATA[1];
  assign push      = dp_done & push_req & ~flush;
  assign take      = acc & HREADYOUT;

  assign space = 6'(DEPTH) - 6'(count);
  assign dreq  = enable & (space >= {1'b0, thresh});

  always_comb begin
    rd_val = 32'd0;
    case (HADDR[3:2])
      2'd1:    rd_val = {22'd0, empty, full, 3'd0, 5'(count)};
      2'd2:    rd_val = {27'd0, thresh};
      2'd3:    rd_val = {31'd0, enable};
      default: rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: HREADYOUT = ~stall;
    endcase
    if (state == S_ERR1)
      state_nxt = S_ERR2;
    else if (stall)
      state_nxt = S_STALL;
    else if (take)
      state_nxt = addr_err ? S_ERR1 : S_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dp_addr  <= 2'd0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      HRDATA   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        dp_addr  <= HADDR[3:2];
        dp_write <= HWRITE;
        dp_word  <= (HSIZE == 3'b010);
        if (!HWRITE && !addr_err)
          HRDATA <= rd_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= 5'd4;
      enable <= 1'b0;
    end else if (reg_wr) begin
      if (dp_addr == 2'd2)
        thresh <= HWDATA[4:0];
      if (dp_addr == 2'd3)
        enable <= HWDATA[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= HWDATA;
  end

endmodule

// File: tb/tb_dmac_ahb_periph_slave.sv
// Bench for dmac_ahb_periph_slave: queue-based bus/FIFO model checked every cycle plus directed literal checks.
module tb_dmac_ahb_periph_slave;
  localparam int DEPTH = 16;
  localparam logic [2:0] W = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = 3'b000;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, dreq, out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  dmac_ahb_periph_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .dreq(dreq), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] q[$];
  bit          m_en = 1'b0;
  logic [4:0]  m_thr = 5'd4;
  bit          pend = 1'b0, pend_wr = 1'b0, pend_word = 1'b0;
  logic [1:0]  pend_reg = 2'd0;
  int          err_cnt = 0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] mdl_rv;
  bit          mdl_rdy, mdl_flush;

  function automatic bit m_pop();
    return m_en && (q.size() != 0) && (out_ready === 1'b1);
  endfunction

  function automatic bit m_ready();
    if (err_cnt == 2) return 1'b0;
    return !(pend && pend_wr && pend_reg == 2'd0 && q.size() == DEPTH && !m_pop());
  endfunction

  function automatic bit m_dreq();
    return m_en && ((DEPTH - q.size()) >= int'(m_thr));
  endfunction

  function automatic logic [31:0] m_head();
    return (q.size() != 0) ? q[0] : 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_en = 1'b0; m_thr = 5'd4; pend = 1'b0; err_cnt = 0; m_rdata = 32'd0;
    end else begin
      mdl_rdy = m_ready();
      mdl_flush = 1'b0;
      case (HADDR[3:2])
        2'd1:    mdl_rv = 32'(q.size()) | ((q.size() == DEPTH) ? 32'h100 : 32'h0) | ((q.size() == 0) ? 32'h200 : 32'h0);
        2'd2:    mdl_rv = {27'd0, m_thr};
        2'd3:    mdl_rv = {31'd0, m_en};
        default: mdl_rv = 32'd0;
      endcase
      if (m_pop()) void'(q.pop_front());
      if (pend && mdl_rdy && pend_wr) begin
        if (pend_reg == 2'd0) q.push_back(HWDATA);
        if (pend_reg == 2'd2 && pend_word) m_thr = HWDATA[4:0];
        if (pend_reg == 2'd3 && pend_word) begin
          m_en = HWDATA[0];
          mdl_flush = HWDATA[1];
        end
      end
      if (mdl_flush) q.delete();
      if (err_cnt == 2) err_cnt = 1;
      else if (mdl_rdy) begin
        err_cnt = 0;
        pend = 1'b0;
        if (HSEL && HTRANS[1]) begin
          if (HADDR[1:0] != 2'b00 || (HWRITE && HADDR[3:2] == 2'd0 && HSIZE != 3'b010))
            err_cnt = 2;
          else begin
            pend = 1'b1; pend_wr = HWRITE; pend_reg = HADDR[3:2]; pend_word = (HSIZE == 3'b010);
            if (!HWRITE) m_rdata = mdl_rv;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and bus driver ----------------
  bit          s_rdy, s_resp, s_dreq;
  logic [31:0] s_odata;

  task automatic tick();
    @(negedge clk);
    chk("HREADYOUT", HREADYOUT, m_ready());
    chk("HRESP", HRESP, (err_cnt != 0));
    chk("HRDATA", HRDATA, m_rdata);
    chk("dreq", dreq, m_dreq());
    chk("out_valid", out_valid, (m_en && q.size() != 0));
    chk("out_data", out_data, m_head());
    s_rdy = HREADYOUT; s_resp = HRESP; s_dreq = dreq; s_odata = out_data;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  xfer_t       xq[$];
  int          waits, pop_after = -1, rst_at = -1;
  logic [31:0] popped;
  bit          dq[$], rdyq[$], rspq[$];

  function automatic xfer_t mk(bit wr, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.size = s; x.data = d;
    return x;
  endfunction

  task automatic run_bus();
    int i = 0, cyc = 0, stalls = 0;
    bit dp = 1'b0, popped_once = 1'b0, abort = 1'b0;
    logic [31:0] pd = 32'd0;
    waits = 0; dq.delete(); rdyq.delete(); rspq.delete();
    while ((i < xq.size() || dp) && cyc < 200 && !abort) begin
      if (i < xq.size()) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = xq[i].addr; HWRITE = xq[i].wr; HSIZE = xq[i].size;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      HWDATA = pd;
      out_ready = (pop_after >= 0 && !popped_once && stalls == pop_after);
      if (cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrst HREADYOUT", HREADYOUT, 1);
        chk("midrst HRESP", HRESP, 0);
        chk("midrst HRDATA", HRDATA, 0);
        chk("midrst dreq", dreq, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 0);
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        rst_n = 1'b1;
        abort = 1'b1;
      end else begin
        tick();
        dq.push_back(s_dreq); rdyq.push_back(s_rdy); rspq.push_back(s_resp);
        if (out_ready) begin
          popped_once = 1'b1;
          popped = s_odata;
        end
        if (!s_rdy) begin
          waits++;
          stalls++;
        end else begin
          dp = (i < xq.size());
          if (dp) begin
            pd = xq[i].data;
            i++;
          end
        end
        cyc++;
      end
    end
    if (!abort && (i < xq.size() || dp)) begin
      tests++; fails++;
      $display("FAIL bus_timeout: got %0d cycles without completion, expected completion", cyc);
    end
    out_ready = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic one(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    xq.delete();
    xq.push_back(mk(wr, a, s, d));
    run_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst HREADYOUT", HREADYOUT, 1);
    chk("rst HRESP", HRESP, 0);
    chk("rst HRDATA", HRDATA, 0);
    chk("rst dreq", dreq, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);

    one(1'b0, 32'h4, W, 0);  chk("STATUS reset", HRDATA, 32'h200);
    one(1'b0, 32'h8, W, 0);  chk("THRESH reset", HRDATA, 32'd4);
    chk("dreq disabled", dreq, 0);

    one(1'b1, 32'hC, W, 32'd1);
    xq.delete();
    for (int k = 0; k < 16; k++) xq.push_back(mk(1'b1, 32'h0, W, 32'h100 + k));
    run_bus();
    chk("16 writes waits", waits, 0);
    chk("16 writes cycles", dq.size(), 17);
    chk("dreq at count 12", dq[13], 1);
    chk("dreq at count 13", dq[14], 0);
    one(1'b0, 32'h4, W, 0);  chk("STATUS full", HRDATA, 32'h110);

    xq.delete();
    xq.push_back(mk(1'b1, 32'h0, W, 32'h999));
    pop_after = 3;
    run_bus();
    pop_after = -1;
    chk("stall waits", waits, 3);
    chk("first pop data", popped, 32'h100);
    one(1'b0, 32'h4, W, 0);  chk("STATUS after stall", HRDATA, 32'h110);

    one(1'b1, 32'h0, 3'b000, 32'hAB);
    chk("byte err HRESP", {rspq[1], rspq[2]}, 2'b11);
    chk("byte err HREADYOUT", {rdyq[1], rdyq[2]}, 2'b01);
    one(1'b0, 32'h4, W, 0);  chk("count after byte err", HRDATA, 32'h110);
    one(1'b0, 32'h5, W, 0);
    chk("misaligned HRESP", {rspq[1], rspq[2]}, 2'b11);
    chk("misaligned HREADYOUT", {rdyq[1], rdyq[2]}, 2'b01);
    chk("HRDATA held after err", HRDATA, 32'h110);

    out_ready = 1'b1;
    repeat (11) tick();
    out_ready = 1'b0;
    one(1'b0, 32'h4, W, 0);  chk("STATUS 5 queued", HRDATA, 32'h005);
    chk("head after drain", out_data, 32'h10C);
    one(1'b1, 32'hC, W, 32'd3);
    chk("flush out_valid", out_valid, 0);
    chk("flush out_data", out_data, 0);
    one(1'b0, 32'h4, W, 0);  chk("STATUS after flush", HRDATA, 32'h200);
    one(1'b0, 32'hC, W, 0);  chk("CTRL readback", HRDATA, 32'd1);

    one(1'b1, 32'h8, W, 32'd0);   chk("dreq thresh 0", dreq, 1);
    one(1'b1, 32'h8, W, 32'd17);  chk("dreq thresh 17", dreq, 0);
    one(1'b1, 32'h8, 3'b000, 32'd2);
    one(1'b0, 32'h8, W, 0);  chk("THRESH byte write ignored", HRDATA, 32'd17);
    one(1'b1, 32'h8, W, 32'd4);

    xq.delete();
    xq.push_back(mk(1'b1, 32'h0, W, 32'hA0));
    xq.push_back(mk(1'b1, 32'h0, W, 32'hA1));
    run_bus();
    one(1'b0, 32'h4, W, 0);  chk("STATUS two queued", HRDATA, 32'h002);
    xq.delete();
    for (int k = 0; k < 4; k++) xq.push_back(mk(1'b1, 32'h0, W, 32'hB0 + k));
    rst_at = 3;
    run_bus();
    rst_at = -1;
    one(1'b0, 32'h4, W, 0);  chk("STATUS after mid reset", HRDATA, 32'h200);
    chk("dreq after mid reset", dreq, 0);
    one(1'b0, 32'h8, W, 0);  chk("THRESH after mid reset", HRDATA, 32'd4);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
